// File: rtl/regfile_sb.sv
// Parametrised NRd-read / NWr-write register file with a per-register pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLen    = 32,
  parameter int NReg    = 32,
  parameter int NRd     = 2,
  parameter int NWr     = 1,
  parameter int ZeroReg = 1,
  localparam int AW     = $clog2(NReg),
  localparam int CW     = $clog2(NReg + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NRd-1:0][AW-1:0]    ra_i,
  output logic [NRd-1:0][XLen-1:0]  rd_o,
  output logic [NRd-1:0]            rbusy_o,
  input  logic [NWr-1:0][AW-1:0]    wa_i,
  input  logic [NWr-1:0]            we_i,
  input  logic [NWr-1:0][XLen-1:0]  wd_i,
  input  logic                      rsv_valid_i,
  input  logic [AW-1:0]             rsv_addr_i,
  output logic                      rsv_ready_o,
  output logic [NReg-1:0]           busy_o,
  output logic [CW-1:0]             pend_cnt_o
);

  localparam bit ZR = (ZeroReg != 0);

  logic [NReg-1:0][XLen-1:0] regs;
  logic [NReg-1:0]           busy;
  logic [NReg-1:0]           busy_nxt;
  logic [CW-1:0]             pend_cnt;
  logic [CW-1:0]             pend_nxt;
  logic [NWr-1:0]            wr_act;
  logic                      rsv_zero;
  logic                      rsv_fire;

  // Writes to the hardwired zero register are dropped entirely, including their busy clear.
  always_comb begin
    wr_act = '0;
    for (int j = 0; j < NWr; j++) begin
      wr_act[j] = we_i[j] && !(ZR && (wa_i[j] == '0));
    end
  end

  assign rsv_zero    = ZR && (rsv_addr_i == '0);
  assign rsv_ready_o = rsv_zero ? 1'b1 : !busy[rsv_addr_i];
  assign rsv_fire    = rsv_valid_i && rsv_ready_o && !rsv_zero;

  // Clears first, then the set: a new producer reserving at the writeback edge keeps the bit.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWr; j++) begin
      if (wr_act[j]) begin
        busy_nxt[wa_i[j]] = 1'b0;
      end
    end
    if (rsv_fire) begin
      busy_nxt[rsv_addr_i] = 1'b1;
    end
  end

  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NReg; i++) begin
      pend_nxt = pend_nxt + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs     <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      // Ascending port order: the highest-indexed port's assignment lands last and wins.
      for (int j = 0; j < NWr; j++) begin
        if (wr_act[j]) begin
          regs[wa_i[j]] <= wd_i[j];
        end
      end
      busy     <= busy_nxt;
      pend_cnt <= pend_nxt;
    end
  end

  always_comb begin
    rd_o    = '0;
    rbusy_o = '0;
    for (int k = 0; k < NRd; k++) begin
      rd_o[k]    = regs[ra_i[k]];
      rbusy_o[k] = busy[ra_i[k]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWr; j++) begin
        if (wr_act[j] && (wa_i[j] == ra_i[k])) begin
          rd_o[k]    = wd_i[j];
          rbusy_o[k] = 1'b0;
        end
      end
`endif
      if (ZR && (ra_i[k] == '0)) begin
        rd_o[k]    = '0;
        rbusy_o[k] = 1'b0;
      end
    end
  end

  assign busy_o     = busy;
  assign pend_cnt_o = pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (2 read ports, 2 write ports, zero register hardwired).
module tb_regfile_sb;

  localparam int XLen = 32;
  localparam int NReg = 32;
  localparam int NRd  = 2;
  localparam int NWr  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic                     clk;
  logic                     rst;
  logic [NRd-1:0][AW-1:0]   ra;
  logic [NRd-1:0][XLen-1:0] rd;
  logic [NRd-1:0]           rbusy;
  logic [NWr-1:0][AW-1:0]   wa;
  logic [NWr-1:0]           we;
  logic [NWr-1:0][XLen-1:0] wd;
  logic                     rsv_valid;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_ready;
  logic [NReg-1:0]          busy;
  logic [CW-1:0]            pend_cnt;

  int checks = 0;
  int errors = 0;
  logic [XLen-1:0] mem [NReg];
  logic [XLen-1:0] exp_byp;

  regfile_sb #(.XLen(XLen), .NReg(NReg), .NRd(NRd), .NWr(NWr), .ZeroReg(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .ra_i(ra), .rd_o(rd), .rbusy_o(rbusy),
    .wa_i(wa), .we_i(we), .wd_i(wd),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .busy_o(busy), .pend_cnt_o(pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ra = '0; wa = '0; we = '0; wd = '0; rsv_valid = 1'b0; rsv_addr = '0;
    #3;
    chk("reset_pend", 64'(pend_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsv_ready", 64'(rsv_ready), 64'd1);
    chk("reset_rd0", 64'(rd[0]), 64'd0);
    #9 rst = 1'b0;
    tick();

    // Sweep: write every register through port 0, then read back on both ports.
    for (int i = 0; i < NReg; i++) begin
      we = 2'b01; wa[0] = AW'(i); wd[0] = $urandom;
      mem[i] = (i == 0) ? '0 : wd[0];
      tick();
    end
    we = '0;
    for (int i = 0; i < NReg; i++) begin
      ra[0] = AW'(i); ra[1] = AW'(NReg - 1 - i);
      #1;
      chk("sweep_rd0", 64'(rd[0]), 64'(mem[i]));
      chk("sweep_rd1", 64'(rd[1]), 64'(mem[NReg-1-i]));
    end

    // Both ports write r5 in the same cycle: port 1 wins.
    we = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5; wd[0] = 32'hAAAA_0000; wd[1] = 32'h5555_FFFF;
    tick();
    we = '0; ra[0] = 5'd5;
    mem[5] = 32'h5555_FFFF;
    #1;
    chk("conflict_r5", 64'(rd[0]), 64'h5555_FFFF);

    // Reserve r7, refuse a second reservation, then clear by writeback.
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1;
    chk("rsv7_ready_idle", 64'(rsv_ready), 64'd1);
    tick();
    ra[1] = 5'd7;
    #1;
    chk("rsv7_busy", 64'(busy[7]), 64'd1);
    chk("rsv7_pend", 64'(pend_cnt), 64'd1);
    chk("rsv7_ready_refused", 64'(rsv_ready), 64'd0);
    chk("rsv7_rbusy", 64'(rbusy[1]), 64'd1);
    tick();
    chk("rsv7_refused_pend", 64'(pend_cnt), 64'd1);
    rsv_valid = 1'b0; we = 2'b01; wa[0] = 5'd7; wd[0] = 32'h0000_0777;
    mem[7] = 32'h0000_0777;
    tick();
    we = '0;
    #1;
    chk("wb7_busy", 64'(busy[7]), 64'd0);
    chk("wb7_pend", 64'(pend_cnt), 64'd0);
    chk("wb7_rbusy", 64'(rbusy[1]), 64'd0);
    chk("wb7_data", 64'(rd[1]), 64'h0000_0777);

    // Register 0 cannot be reserved but is always ready.
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1;
    chk("rsv0_ready", 64'(rsv_ready), 64'd1);
    tick();
    rsv_valid = 1'b0;
    chk("rsv0_busy", 64'(busy), 64'd0);
    chk("rsv0_pend", 64'(pend_cnt), 64'd0);

    // Reserve and write r9 in the same cycle: the reservation wins.
    rsv_valid = 1'b1; rsv_addr = 5'd9; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h0000_1234;
    mem[9] = 32'h0000_1234;
    tick();
    rsv_valid = 1'b0; we = '0; ra[0] = 5'd9;
    #1;
    chk("setwins_busy9", 64'(busy[9]), 64'd1);
    chk("setwins_rd9", 64'(rd[0]), 64'h0000_1234);
    chk("setwins_pend", 64'(pend_cnt), 64'd1);

    // Add r10, then clear r9 and r10 through both ports at once.
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    tick();
    rsv_valid = 1'b0;
    chk("two_pend", 64'(pend_cnt), 64'd2);
    we = 2'b11; wa[0] = 5'd9; wa[1] = 5'd10; wd[0] = 32'h9999_0000; wd[1] = 32'h1010_1010;
    mem[9] = 32'h9999_0000; mem[10] = 32'h1010_1010;
    tick();
    we = '0;
    chk("dual_clear_pend", 64'(pend_cnt), 64'd0);
    chk("dual_clear_busy", 64'(busy), 64'd0);

    // Same-cycle write and read of r3.
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hDEAD_BEEF;
`else
    exp_byp = mem[3];
`endif
    we = 2'b01; wa[0] = 5'd3; wd[0] = 32'hDEAD_BEEF; ra[0] = 5'd3; ra[1] = 5'd0;
    #1;
    chk("bypass_same_cycle", 64'(rd[0]), 64'(exp_byp));
    chk("bypass_zero_reg", 64'(rd[1]), 64'd0);
    tick();
    we = '0;
    mem[3] = 32'hDEAD_BEEF;
    #1;
    chk("bypass_next_cycle", 64'(rd[0]), 64'hDEAD_BEEF);

    // Asynchronous reset mid-cycle with a pending reservation and an active write request.
    rsv_valid = 1'b1; rsv_addr = 5'd11;
    tick();
    chk("pre_reset_pend", 64'(pend_cnt), 64'd1);
    we = 2'b01; wa[0] = 5'd12; wd[0] = 32'hCAFE_F00D; rsv_addr = 5'd13;
    #1 rst = 1'b1;
    #1;
    chk("async_reset_rd0", 64'(rd[0]), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_pend", 64'(pend_cnt), 64'd0);
    chk("async_reset_ready", 64'(rsv_ready), 64'd1);
    tick();
    ra[0] = 5'd12;
    #1;
    chk("held_reset_write", 64'(rd[0]), 64'd0);
    chk("held_reset_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
